// File: rtl/coeff_bank_server.sv
// Double-buffered coefficient memory for the 8-channel filter bank.
// The host fills the shadow bank, and a commit swaps the banks on a sample boundary.
module coeff_bank_server #(
  parameter int unsigned NTAPS = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned CW    = 36
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] coeffaddress,
  input  logic          din_enable,
  output logic [CW-1:0] coeff0,
  output logic [CW-1:0] coeff1,
  output logic [CW-1:0] coeff2,
  output logic [CW-1:0] coeff3,
  output logic [CW-1:0] coeff4,
  output logic [CW-1:0] coeff5,
  output logic [CW-1:0] coeff6,
  output logic [CW-1:0] coeff7,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [2:0]    wr_chan,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          commit,
  output logic          busy,
  output logic          bank_sel,
  output logic          swap_pulse
);

  localparam int unsigned NCH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COPY    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] cnt;
  logic          swap_c;
  logic          copy_en_c;
  logic          wr_en_c;
  logic          rb_c;

  logic [CW-1:0] mem [2][NCH][NTAPS];
  logic [CW-1:0] coeff_q [NCH];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit)                    state_nxt = PENDING;
      PENDING: if (din_enable)                state_nxt = COPY;
      COPY:    if (cnt == AW'(NTAPS - 1))     state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  // Outputs and internal strobes decoded from state
  always_comb begin
    wr_ready  = 1'b0;
    busy      = 1'b0;
    swap_c    = 1'b0;
    copy_en_c = 1'b0;
    case (state)
      IDLE:    wr_ready = 1'b1;
      PENDING: begin
        busy   = 1'b1;
        swap_c = din_enable;
      end
      COPY: begin
        busy      = 1'b1;
        copy_en_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_en_c = wr_valid & wr_ready;
  // The read in the swap cycle already targets the incoming bank.
  assign rb_c    = bank_sel ^ swap_c;

  // Bank select, copy counter and registered read port
  always_ff @(posedge clock) begin
    if (reset) begin
      bank_sel   <= 1'b0;
      swap_pulse <= 1'b0;
      cnt        <= '0;
      for (int ch = 0; ch < NCH; ch++) coeff_q[ch] <= '0;
    end else begin
      swap_pulse <= swap_c;
      if (swap_c) bank_sel <= ~bank_sel;
      if (swap_c)         cnt <= '0;
      else if (copy_en_c) cnt <= cnt + AW'(1);
      for (int ch = 0; ch < NCH; ch++) coeff_q[ch] <= mem[rb_c][ch][coeffaddress];
    end
  end

  // Storage is never cleared; reset only blocks updates on that edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (wr_en_c) mem[~bank_sel][wr_chan][wr_addr] <= wr_data;
      if (copy_en_c) begin
        for (int ch = 0; ch < NCH; ch++) mem[~bank_sel][ch][cnt] <= mem[bank_sel][ch][cnt];
      end
    end
  end

  assign coeff0 = coeff_q[0];
  assign coeff1 = coeff_q[1];
  assign coeff2 = coeff_q[2];
  assign coeff3 = coeff_q[3];
  assign coeff4 = coeff_q[4];
  assign coeff5 = coeff_q[5];
  assign coeff6 = coeff_q[6];
  assign coeff7 = coeff_q[7];

endmodule

// File: tb/tb_coeff_bank_server.sv
// Directed bench for coeff_bank_server: load, publish, pending hold, partial update,
// simultaneous write/commit, reset during copy and commits ignored while busy.
module tb_coeff_bank_server;

  localparam int unsigned AW = 6;
  localparam int unsigned CW = 36;

  logic          clock;
  logic          reset;
  logic [AW-1:0] coeffaddress;
  logic          din_enable;
  logic [CW-1:0] coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7;
  logic          wr_valid;
  logic          wr_ready;
  logic [2:0]    wr_chan;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic          commit;
  logic          busy;
  logic          bank_sel;
  logic          swap_pulse;

  int checks   = 0;
  int failures = 0;
  int n;

  coeff_bank_server #(.NTAPS(64), .AW(AW), .CW(CW)) dut (
    .clock(clock), .reset(reset), .coeffaddress(coeffaddress), .din_enable(din_enable),
    .coeff0(coeff0), .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3),
    .coeff4(coeff4), .coeff5(coeff5), .coeff6(coeff6), .coeff7(coeff7),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .busy(busy), .bank_sel(bank_sel),
    .swap_pulse(swap_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [2:0] ch, input logic [AW-1:0] a, input logic [CW-1:0] d);
    wr_valid = 1'b1; wr_chan = ch; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b1; coeffaddress = '0; din_enable = 1'b0; wr_valid = 1'b0;
    wr_chan = '0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    tick(); tick();
    chk("rst_coeff0", 64'(coeff0), 64'd0);
    chk("rst_coeff7", 64'(coeff7), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_bank_sel", 64'(bank_sel), 64'd0);
    chk("rst_swap_pulse", 64'(swap_pulse), 64'd0);
    reset = 1'b0;

    // Load and publish: ch0 = tap+1, ch3 = 0xA00+tap
    for (int i = 0; i < 64; i++) write(3'd0, AW'(i), CW'(i + 1));
    for (int i = 0; i < 64; i++) write(3'd3, AW'(i), CW'(36'hA00 + i));
    commit = 1'b1; tick(); commit = 1'b0;
    chk("s1_pending_busy", 64'(busy), 64'd1);
    chk("s1_pending_ready", 64'(wr_ready), 64'd0);
    din_enable = 1'b1; coeffaddress = AW'(5); tick(); din_enable = 1'b0;
    chk("s1_swap_pulse", 64'(swap_pulse), 64'd1);
    chk("s1_bank_sel", 64'(bank_sel), 64'd1);
    chk("s1_coeff0_addr5", 64'(coeff0), 64'd6);
    tick();
    chk("s1_swap_pulse_drop", 64'(swap_pulse), 64'd0);
    n = 1;
    while (!wr_ready && n < 200) begin
      tick();
      n++;
    end
    chk("s3_copy_cycles", 64'(n), 64'd64);
    coeffaddress = AW'(63); tick();
    chk("s1_coeff0_addr63", 64'(coeff0), 64'd64);

    // Partial update of ch3 tap10 in the refreshed shadow bank
    write(3'd3, AW'(10), 36'h123456789);
    commit = 1'b1; tick(); commit = 1'b0;
    din_enable = 1'b1; coeffaddress = AW'(10); tick(); din_enable = 1'b0;
    chk("s3_bank_sel", 64'(bank_sel), 64'd0);
    chk("s3_coeff3_addr10", 64'(coeff3), 64'h123456789);
    wait_idle(n);
    chk("s3_idle_cycles", 64'(n), 64'd64);
    coeffaddress = AW'(11); tick();
    chk("s3_coeff3_addr11", 64'(coeff3), 64'hA0B);
    coeffaddress = AW'(20); tick();
    chk("s3_coeff0_addr20", 64'(coeff0), 64'd21);

    // Pending hold, with an extra commit and blocked writes while pending
    write(3'd0, AW'(5), 36'hFFF);
    commit = 1'b1; tick(); commit = 1'b0;
    coeffaddress = AW'(5);
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_chan = 3'd0; wr_addr = AW'(6); wr_data = 36'h777;
      commit = (i == 3);
      tick();
    end
    wr_valid = 1'b0; commit = 1'b0;
    chk("s2_busy", 64'(busy), 64'd1);
    chk("s2_wr_ready", 64'(wr_ready), 64'd0);
    chk("s2_bank_sel", 64'(bank_sel), 64'd0);
    chk("s2_coeff0_old_bank", 64'(coeff0), 64'd6);
    din_enable = 1'b1; coeffaddress = AW'(6); tick(); din_enable = 1'b0;
    chk("s2_bank_sel_swapped", 64'(bank_sel), 64'd1);
    chk("s2_coeff0_addr6", 64'(coeff0), 64'd7);

    // Commit and din_enable during COPY are ignored
    n = 0;
    while (busy && n < 200) begin
      commit = (n == 10); din_enable = (n == 10);
      tick();
      n++;
    end
    commit = 1'b0; din_enable = 1'b0;
    chk("s6_copy_cycles", 64'(n), 64'd64);
    chk("s6_bank_sel", 64'(bank_sel), 64'd1);
    tick(); tick();
    chk("s6_still_idle", 64'(busy), 64'd0);
    chk("s6_no_second_swap", 64'(bank_sel), 64'd1);
    coeffaddress = AW'(5); tick();
    chk("s2_coeff0_addr5_new", 64'(coeff0), 64'hFFF);

    // Simultaneous write and commit
    wr_valid = 1'b1; wr_chan = 3'd7; wr_addr = AW'(0); wr_data = 36'h800000001;
    commit = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    chk("s4_pending", 64'(busy), 64'd1);
    din_enable = 1'b1; coeffaddress = AW'(0); tick(); din_enable = 1'b0;
    chk("s4_bank_sel", 64'(bank_sel), 64'd0);
    chk("s4_coeff7_addr0", 64'(coeff7), 64'h800000001);
    wait_idle(n);
    chk("s4_idle_cycles", 64'(n), 64'd64);

    // Reset at COPY cycle 30
    commit = 1'b1; tick(); commit = 1'b0;
    din_enable = 1'b1; tick(); din_enable = 1'b0;
    chk("s5_bank_sel_swapped", 64'(bank_sel), 64'd1);
    for (int i = 0; i < 30; i++) tick();
    chk("s5_busy_in_copy", 64'(busy), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s5_bank_sel", 64'(bank_sel), 64'd0);
    chk("s5_busy", 64'(busy), 64'd0);
    chk("s5_wr_ready", 64'(wr_ready), 64'd1);
    chk("s5_coeff0", 64'(coeff0), 64'd0);
    chk("s5_coeff3", 64'(coeff3), 64'd0);
    chk("s5_coeff7", 64'(coeff7), 64'd0);

    // Fresh publish after reset behaves like the first one
    write(3'd0, AW'(5), CW'(6));
    commit = 1'b1; tick(); commit = 1'b0;
    din_enable = 1'b1; coeffaddress = AW'(5); tick(); din_enable = 1'b0;
    chk("s5_swap_pulse", 64'(swap_pulse), 64'd1);
    chk("s5_bank_sel_new", 64'(bank_sel), 64'd1);
    chk("s5_coeff0_addr5", 64'(coeff0), 64'd6);
    wait_idle(n);
    chk("s5_copy_cycles", 64'(n), 64'd64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
